// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with redirect/trap steering, stall-time pending buffer and halt.
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                STEP       = 4,
  parameter int                ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_pc,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [ADDR_W-1:0] npc,
  output logic              flush,
  output logic              misalign
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, tgt, load_pc;
  logic              pend_valid_q, pend_valid_d, pend_trap_q, pend_trap_d;
  logic              flush_q, flush_d, misalign_q, misalign_d, tgt_any, load;
  assign tgt_any     = trap_valid | redirect_valid;
  assign tgt         = trap_valid ? trap_pc : redirect_pc;
  assign fetch_valid = (state_q == RUN) && !stall && !pend_valid_q;
  assign fetch_pc    = pc_q;
  assign npc         = pc_q + ADDR_W'(STEP);
  assign flush       = flush_q;
  assign misalign    = misalign_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    pend_trap_d  = pend_trap_q;
    load         = 1'b0;
    load_pc      = tgt;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          if (tgt_any || pend_valid_q) begin
            load         = 1'b1;
            load_pc      = tgt_any ? tgt : pend_pc_q;
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
          end else if (halt_req) begin
            state_d = HALT;
          end else if (fetch_valid && fetch_ready) begin
            pc_d = npc;
          end
        end else if (tgt_any && (trap_valid || !pend_trap_q)) begin
          // a buffered trap is never displaced by a later branch
          pend_valid_d = 1'b1;
          pend_pc_d    = tgt;
          pend_trap_d  = trap_valid;
        end
      end
      HALT: begin
        load    = trap_valid;
        load_pc = trap_pc;
        state_d = trap_valid ? RUN : HALT;
      end
      default: state_d = BOOT;
    endcase
    pc_d       = load ? (load_pc & ~LOW_MASK) : pc_d;
    flush_d    = load;
    misalign_d = load && |(load_pc & LOW_MASK);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      pend_trap_q  <= 1'b0;
      flush_q      <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      pend_trap_q  <= pend_trap_d;
      flush_q      <= flush_d;
      misalign_q   <= misalign_d;
    end
  end
endmodule
